// File: rtl/inst_fetch_queue.sv
// Instruction fetch front end: sequential word fetch with request/grant,
// in-order variable-latency responses buffered in a small queue toward decode.
module inst_fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        valid_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W:0]   DEPTH_L  = (CNT_W + 1)'(DEPTH);
  localparam logic [31:0]      WORD_INC = 32'd4;

  logic [31:0]      fetch_pc_r;
  logic [31:0]      resp_pc_r;
  logic [31:0]      q_pc_r   [DEPTH];
  logic [31:0]      q_inst_r [DEPTH];
  logic [PTR_W-1:0] head_r;
  logic [PTR_W-1:0] tail_r;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] outstanding_r;
  logic [CNT_W-1:0] discard_cnt_r;

  logic [CNT_W:0]   credits_s;
  logic             req_s;
  logic             grant_s;
  logic             resp_s;
  logic             push_s;
  logic             pop_s;
  logic             valid_s;
  logic [31:0]      target_s;
  logic [CNT_W-1:0] out_nxt_s;
  logic [CNT_W-1:0] disc_nxt_s;
  logic [CNT_W-1:0] cnt_nxt_s;

  // Handshake decode and next-state for the counters
  always_comb begin
    credits_s  = {1'b0, count_r} + {1'b0, outstanding_r};
    req_s      = rst & ~redirect_i & (credits_s < DEPTH_L);
    grant_s    = req_s & imem_gnt_i;
    resp_s     = imem_rvalid_i & (outstanding_r != CNT_ZERO);
    valid_s    = (count_r != CNT_ZERO) & ~redirect_i;
    pop_s      = valid_s & ~stall_i;
    target_s   = redirect_pc_i & 32'hFFFF_FFFC;
    push_s     = 1'b0;
    out_nxt_s  = outstanding_r;
    disc_nxt_s = discard_cnt_r;
    cnt_nxt_s  = count_r;
    if (redirect_i) begin
      // Everything still in flight after this cycle belongs to the old path
      out_nxt_s  = resp_s ? (outstanding_r - CNT_ONE) : outstanding_r;
      disc_nxt_s = out_nxt_s;
      cnt_nxt_s  = CNT_ZERO;
    end else begin
      case ({grant_s, resp_s})
        2'b10:   out_nxt_s = outstanding_r + CNT_ONE;
        2'b01:   out_nxt_s = outstanding_r - CNT_ONE;
        default: out_nxt_s = outstanding_r;
      endcase
      if (resp_s) begin
        if (discard_cnt_r != CNT_ZERO) begin
          disc_nxt_s = discard_cnt_r - CNT_ONE;
        end else begin
          push_s = 1'b1;
        end
      end else begin
        disc_nxt_s = discard_cnt_r;
      end
      case ({push_s, pop_s})
        2'b10:   cnt_nxt_s = count_r + CNT_ONE;
        2'b01:   cnt_nxt_s = count_r - CNT_ONE;
        default: cnt_nxt_s = count_r;
      endcase
    end
  end

  // Control state: pcs, pointers and counters
  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc_r    <= RESET_PC;
      resp_pc_r     <= RESET_PC;
      head_r        <= PTR_ZERO;
      tail_r        <= PTR_ZERO;
      count_r       <= CNT_ZERO;
      outstanding_r <= CNT_ZERO;
      discard_cnt_r <= CNT_ZERO;
    end else begin
      count_r       <= cnt_nxt_s;
      outstanding_r <= out_nxt_s;
      discard_cnt_r <= disc_nxt_s;
      if (redirect_i) begin
        fetch_pc_r <= target_s;
        resp_pc_r  <= target_s;
        head_r     <= PTR_ZERO;
        tail_r     <= PTR_ZERO;
      end else begin
        if (grant_s) begin
          fetch_pc_r <= fetch_pc_r + WORD_INC;
        end
        if (push_s) begin
          tail_r    <= tail_r + PTR_ONE;
          resp_pc_r <= resp_pc_r + WORD_INC;
        end
        if (pop_s) begin
          head_r <= head_r + PTR_ONE;
        end
      end
    end
  end

  // Queue storage; contents are only observed through count, so no reset
  always_ff @(posedge clk) begin
    if (rst && push_s) begin
      q_pc_r[tail_r]   <= resp_pc_r;
      q_inst_r[tail_r] <= imem_rdata_i;
    end
  end

  // Decode-side outputs; an empty slot presents a nop at pc 0
  always_comb begin
    valid_o = valid_s;
    if (valid_s) begin
      pc_o   = q_pc_r[head_r];
      inst_o = q_inst_r[head_r];
    end else begin
      pc_o   = 32'h0000_0000;
      inst_o = 32'h0000_0000;
    end
  end

  assign imem_req_o  = req_s;
  assign imem_addr_o = fetch_pc_r;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue: the bench plays instruction memory
// cycle by cycle; instruction data for address A is {16'hC0DE, A[15:0]}.
module tb_inst_fetch_queue;

  logic        clk;
  logic        rst;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        valid_o;

  int n_cmp = 0;
  int n_err = 0;

  inst_fetch_queue #(
    .RESET_PC(32'hBFC0_0000),
    .DEPTH   (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_gnt_i   (imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i),
    .imem_rdata_i (imem_rdata_i),
    .stall_i      (stall_i),
    .redirect_i   (redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .pc_o         (pc_o),
    .inst_o       (inst_o),
    .valid_o      (valid_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic restart(input logic [31:0] pc);
    rst = 1'b0; imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0;
    stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0;
    #1;
    chk("rst_req", {31'b0, imem_req_o}, 32'd0);
    tick();
    rst = 1'b1; redirect_i = 1'b1; redirect_pc_i = pc;
    #1;
    chk("redir_req", {31'b0, imem_req_o}, 32'd0);
    chk("redir_valid", {31'b0, valid_o}, 32'd0);
    tick();
    redirect_i = 1'b0;
  endtask

  initial begin
    rst = 1'b0; imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0;
    stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0;
    tick();
    tick();
    #1;
    chk("reset_req", {31'b0, imem_req_o}, 32'd0);
    chk("reset_valid", {31'b0, valid_o}, 32'd0);
    chk("reset_pc", pc_o, 32'h0);

    // 1: streaming from RESET_PC, grant always, 1-cycle latency
    rst = 1'b1; imem_gnt_i = 1'b1;
    #1;
    chk("t1_req0", {31'b0, imem_req_o}, 32'd1);
    chk("t1_addr0", imem_addr_o, 32'hBFC0_0000);
    chk("t1_valid0", {31'b0, valid_o}, 32'd0);
    tick();
    for (int i = 1; i <= 5; i++) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = 32'hC0DE_0000 + 32'(4 * (i - 1));
      #1;
      chk("t1_addr", imem_addr_o, 32'hBFC0_0000 + 32'(4 * i));
      if (i == 1) begin
        chk("t1_valid_lat", {31'b0, valid_o}, 32'd0);
      end else begin
        chk("t1_valid", {31'b0, valid_o}, 32'd1);
        chk("t1_pc", pc_o, 32'hBFC0_0000 + 32'(4 * (i - 2)));
        chk("t1_inst", inst_o, 32'hC0DE_0000 + 32'(4 * (i - 2)));
      end
      tick();
    end

    // 2: decode stalled fills the queue, then drains in order
    restart(32'h0);
    stall_i = 1'b1; imem_gnt_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      imem_rvalid_i = (i != 0);
      imem_rdata_i  = 32'hC0DE_0000 + 32'(4 * (i - 1));
      #1;
      chk("t2_req", {31'b0, imem_req_o}, 32'd1);
      chk("t2_addr", imem_addr_o, 32'(4 * i));
      tick();
    end
    imem_rvalid_i = 1'b1; imem_rdata_i = 32'hC0DE_000C;
    #1;
    chk("t2_full_req", {31'b0, imem_req_o}, 32'd0);
    chk("t2_stall_pc", pc_o, 32'h0);
    tick();
    imem_rvalid_i = 1'b0;
    #1;
    chk("t2_full_req2", {31'b0, imem_req_o}, 32'd0);
    tick();
    stall_i = 1'b0; imem_gnt_i = 1'b0;
    #1;
    chk("t2_pop_req", {31'b0, imem_req_o}, 32'd0);
    chk("t2_pc0", pc_o, 32'h0);
    chk("t2_inst0", inst_o, 32'hC0DE_0000);
    tick();
    #1;
    chk("t2_resume_req", {31'b0, imem_req_o}, 32'd1);
    chk("t2_resume_addr", imem_addr_o, 32'h10);
    chk("t2_pc4", pc_o, 32'h4);
    tick();
    #1;
    chk("t2_pc8", pc_o, 32'h8);
    tick();
    #1;
    chk("t2_pcC", pc_o, 32'hC);
    chk("t2_instC", inst_o, 32'hC0DE_000C);
    tick();
    #1;
    chk("t2_empty", {31'b0, valid_o}, 32'd0);
    chk("t2_addr_hold", imem_addr_o, 32'h10);

    // 4: grant withheld, address holds, single increment on grant
    restart(32'h200);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t4_req", {31'b0, imem_req_o}, 32'd1);
      chk("t4_addr", imem_addr_o, 32'h200);
      tick();
    end
    imem_gnt_i = 1'b1;
    #1;
    chk("t4_addr_gnt", imem_addr_o, 32'h200);
    tick();
    imem_gnt_i = 1'b0;
    #1;
    chk("t4_addr_next", imem_addr_o, 32'h204);
    chk("t4_req_next", {31'b0, imem_req_o}, 32'd1);

    // 3: redirect with two 3-cycle-latency fetches outstanding
    restart(32'h0);
    imem_gnt_i = 1'b1;
    tick();
    tick();
    imem_gnt_i = 1'b0; redirect_i = 1'b1; redirect_pc_i = 32'h100;
    #1;
    chk("t3_redir_req", {31'b0, imem_req_o}, 32'd0);
    tick();
    redirect_i = 1'b0; imem_gnt_i = 1'b1; imem_rvalid_i = 1'b1; imem_rdata_i = 32'hC0DE_0000;
    #1;
    chk("t3_new_addr", imem_addr_o, 32'h100);
    chk("t3_new_req", {31'b0, imem_req_o}, 32'd1);
    tick();
    imem_gnt_i = 1'b0; imem_rdata_i = 32'hC0DE_0004;
    #1;
    chk("t3_addr_after", imem_addr_o, 32'h104);
    tick();
    imem_rvalid_i = 1'b0;
    #1;
    chk("t3_drop_valid", {31'b0, valid_o}, 32'd0);
    tick();
    imem_rvalid_i = 1'b1; imem_rdata_i = 32'hC0DE_0100;
    #1;
    chk("t3_pre_valid", {31'b0, valid_o}, 32'd0);
    tick();
    imem_rvalid_i = 1'b0;
    #1;
    chk("t3_valid", {31'b0, valid_o}, 32'd1);
    chk("t3_pc", pc_o, 32'h100);
    chk("t3_inst", inst_o, 32'hC0DE_0100);
    tick();

    // 5: redirect to unaligned target with a response in the same cycle
    restart(32'h0);
    stall_i = 1'b1; imem_gnt_i = 1'b1;
    tick();
    imem_rvalid_i = 1'b1; imem_rdata_i = 32'hC0DE_0000;
    tick();
    imem_rvalid_i = 1'b0;
    #1;
    chk("t5_valid_pre", {31'b0, valid_o}, 32'd1);
    tick();
    imem_gnt_i = 1'b0; redirect_i = 1'b1; redirect_pc_i = 32'h103;
    imem_rvalid_i = 1'b1; imem_rdata_i = 32'hC0DE_0004;
    #1;
    chk("t5_redir_valid", {31'b0, valid_o}, 32'd0);
    chk("t5_redir_pc", pc_o, 32'h0);
    chk("t5_redir_req", {31'b0, imem_req_o}, 32'd0);
    tick();
    redirect_i = 1'b0; stall_i = 1'b0; imem_rvalid_i = 1'b0;
    #1;
    chk("t5_addr", imem_addr_o, 32'h100);
    chk("t5_req", {31'b0, imem_req_o}, 32'd1);
    tick();
    imem_rvalid_i = 1'b1; imem_rdata_i = 32'hC0DE_0008;
    tick();
    imem_rvalid_i = 1'b0; imem_gnt_i = 1'b1;
    #1;
    chk("t5_drop_valid", {31'b0, valid_o}, 32'd0);
    chk("t5_addr_hold", imem_addr_o, 32'h100);
    tick();
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'hC0DE_0100;
    #1;
    chk("t5_pre_valid", {31'b0, valid_o}, 32'd0);
    tick();
    imem_rvalid_i = 1'b0;
    #1;
    chk("t5_valid", {31'b0, valid_o}, 32'd1);
    chk("t5_pc", pc_o, 32'h100);
    chk("t5_inst", inst_o, 32'hC0DE_0100);

    // 6: reset with fetches in flight and instructions queued
    restart(32'h0);
    stall_i = 1'b1; imem_gnt_i = 1'b1;
    tick();
    imem_rvalid_i = 1'b1; imem_rdata_i = 32'hC0DE_0000;
    tick();
    imem_rdata_i = 32'hC0DE_0004;
    tick();
    imem_rvalid_i = 1'b0;
    tick();
    #1;
    chk("t6_cap_req", {31'b0, imem_req_o}, 32'd0);
    rst = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'hDEAD_BEEF;
    #1;
    chk("t6_rst_req", {31'b0, imem_req_o}, 32'd0);
    tick();
    rst = 1'b1; imem_gnt_i = 1'b0; stall_i = 1'b0;
    #1;
    chk("t6_valid", {31'b0, valid_o}, 32'd0);
    chk("t6_pc", pc_o, 32'h0);
    chk("t6_inst", inst_o, 32'h0);
    chk("t6_req", {31'b0, imem_req_o}, 32'd1);
    chk("t6_addr", imem_addr_o, 32'hBFC0_0000);
    tick();
    #1;
    chk("t6_stray_valid", {31'b0, valid_o}, 32'd0);
    tick();
    imem_rvalid_i = 1'b0; imem_gnt_i = 1'b1;
    #1;
    chk("t6_stray_valid2", {31'b0, valid_o}, 32'd0);
    chk("t6_addr_gnt", imem_addr_o, 32'hBFC0_0000);
    tick();
    imem_gnt_i = 1'b0;
    #1;
    chk("t6_addr_next", imem_addr_o, 32'hBFC0_0004);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
